// File: rtl/apb_slave_memory_param.sv
// APB4 completer memory with configurable width/depth, byte strobes,
// programmable wait states and alignment/range error reporting.
module apb_slave_memory_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int ALIGN = (NB > 1) ? $clog2(NB) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  access;
    logic                  exec;
    logic [ADDR_WIDTH-1:0] idx;
    logic [IDX_W-1:0]      widx;
    logic                  misalign;
    logic                  out_of_range;
    logic                  err;

    assign access       = psel & penable;
    assign idx          = paddr >> ALIGN;
    assign widx         = idx[IDX_W-1:0];
    assign misalign     = |(paddr & ADDR_WIDTH'(NB - 1));
    // Full-width compare: stray upper address bits land here as range errors.
    assign out_of_range = (idx >= ADDR_WIDTH'(DEPTH));
    assign err          = misalign | out_of_range;

    assign exec = access & (((state_q == S_IDLE) && (WAIT_STATES == 0)) ||
                            ((state_q == S_WAIT) && (cnt_q == 4'd1)));

    always_ff @(posedge pclk) begin
        if (preset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (access) state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (!psel)     state_d = S_IDLE;
                else if (exec) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pready = (state_q == S_RESP);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt_q <= 4'd0;
        end else if ((state_q == S_IDLE) && access) begin
            cnt_q <= 4'(WAIT_STATES);
        end else if ((state_q == S_WAIT) && access && (cnt_q != 4'd1)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Execute stage: memory update and response capture on the edge entering RESP.
    always_ff @(posedge pclk) begin
        if (preset) begin
            prdata  <= '0;
            pslverr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (exec) begin
            pslverr <= err;
            if (err) begin
                if (!pwrite) prdata <= '0;
            end else if (pwrite) begin
                for (int b = 0; b < NB; b++)
                    if (pstrb[b]) mem[widx][8*b +: 8] <= pwdata[8*b +: 8];
            end else begin
                prdata <= mem[widx];
            end
        end else if (state_q == S_RESP) begin
            pslverr <= 1'b0;
        end
    end

endmodule
